// File: rtl/pong_pkg.sv
// Shared constants, debounce state encoding and speed helper for the pong
// input-conditioning logic.
package pong_pkg;

  localparam int unsigned BTN_COUNT = 4;
  localparam int unsigned SPEED_W   = 4;

  localparam logic [SPEED_W-1:0] DEFAULT_SPEED = 4'd4;
  localparam logic [SPEED_W-1:0] MIN_SPEED     = 4'd1;

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } deb_state_t;

  // A zero DIP setting would freeze the object, so clamp it up to the minimum.
  function automatic logic [SPEED_W-1:0] floor_speed(input logic [SPEED_W-1:0] s);
    return (s == '0) ? MIN_SPEED : s;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: input synchronizer, four-state debounce FSM with a
// saturating-free 16-bit hold counter, and a rising-edge pulse.
module debounce_channel
  import pong_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  deb_state_t             state;
  logic [15:0]            cnt;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  // clean/rise update on the same edge as the STABLE_HI/LO entry, so the
  // accepted level appears SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after sampling.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      unique case (state)
        STABLE_LO: begin
          if (level) begin
            state <= PEND_HI;
            cnt   <= '0;
          end
        end
        STABLE_HI: begin
          if (!level) begin
            state <= PEND_LO;
            cnt   <= '0;
          end
        end
        PEND_HI: begin
          if (!level) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            clean <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PEND_LO: begin
          if (level) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            clean <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_speed_conditioner.sv
// Conditions pad buttons (debounce + rise pulses) and latches DIP speed
// settings once per frame so gameplay sees stable values.
module btn_speed_conditioner
  import pong_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [BTN_COUNT-1:0]   btns_raw,
  input  logic [2*SPEED_W-1:0]   speed_raw,
  input  logic                   force_fallback,
  input  logic                   frame_tick,
  output logic [BTN_COUNT-1:0]   btns_clean,
  output logic [BTN_COUNT-1:0]   btns_rise,
  output logic [SPEED_W-1:0]     ball_speed,
  output logic [SPEED_W-1:0]     player_speed,
  output logic                   cfg_update
);

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .CLK  (CLK),
      .rst_n(rst_n),
      .raw  (btns_raw[i]),
      .clean(btns_clean[i]),
      .rise (btns_rise[i])
    );
  end

  // {force_fallback, speed_raw} share one synchronizer chain of equal depth.
  logic [2*SPEED_W:0] cfg_sync [SYNC_STAGES];
  logic [2*SPEED_W:0] cfg_s;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        cfg_sync[i] <= '0;
      end
    end else begin
      cfg_sync[0] <= {force_fallback, speed_raw};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        cfg_sync[i] <= cfg_sync[i-1];
      end
    end
  end

  assign cfg_s = cfg_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      ball_speed   <= DEFAULT_SPEED;
      player_speed <= DEFAULT_SPEED;
      cfg_update   <= 1'b0;
    end else begin
      cfg_update <= frame_tick;
      if (frame_tick) begin
        if (cfg_s[2*SPEED_W]) begin
          ball_speed   <= DEFAULT_SPEED;
          player_speed <= DEFAULT_SPEED;
        end else begin
          ball_speed   <= floor_speed(cfg_s[SPEED_W-1:0]);
          player_speed <= floor_speed(cfg_s[2*SPEED_W-1:SPEED_W]);
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_speed_conditioner.sv
// Directed bench for btn_speed_conditioner with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
module tb_btn_speed_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btns_raw;
  logic [7:0] speed_raw;
  logic       force_fallback;
  logic       frame_tick;
  logic [3:0] btns_clean;
  logic [3:0] btns_rise;
  logic [3:0] ball_speed;
  logic [3:0] player_speed;
  logic       cfg_update;

  int unsigned checks = 0;
  int unsigned errors = 0;

  btn_speed_conditioner #(
    .DEBOUNCE_CYCLES(16'd8),
    .SYNC_STAGES    (2)
  ) dut (
    .CLK           (clk),
    .rst_n         (rst_n),
    .btns_raw      (btns_raw),
    .speed_raw     (speed_raw),
    .force_fallback(force_fallback),
    .frame_tick    (frame_tick),
    .btns_clean    (btns_clean),
    .btns_rise     (btns_rise),
    .ball_speed    (ball_speed),
    .player_speed  (player_speed),
    .cfg_update    (cfg_update)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc_clean;
    logic [3:0] acc_rise;

    rst_n = 1'b0; btns_raw = '0; speed_raw = '0; force_fallback = 1'b0; frame_tick = 1'b0;
    tick(3);
    check_eq("rst_clean", btns_clean, 4'h0);
    check_eq("rst_rise", btns_rise, 4'h0);
    check_eq("rst_ball", ball_speed, 4'd4);
    check_eq("rst_player", player_speed, 4'd4);
    check_eq("rst_cfg", cfg_update, 1'b0);

    // p1Up pressed from reset release: accepted on the 11th edge
    btns_raw = 4'b1000; rst_n = 1'b1;
    tick(10);
    check_eq("hi_edge10_clean", btns_clean, 4'h0);
    check_eq("hi_edge10_rise", btns_rise, 4'h0);
    tick();
    check_eq("hi_edge11_clean", btns_clean, 4'b1000);
    check_eq("hi_edge11_rise", btns_rise, 4'b1000);
    tick();
    check_eq("hi_edge12_rise", btns_rise, 4'h0);
    check_eq("hi_edge12_clean", btns_clean, 4'b1000);

    // release: same latency, no rise pulse on the falling edge
    btns_raw = 4'b0000;
    acc_rise = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc_rise |= btns_rise;
    end
    check_eq("lo_edge10_clean", btns_clean, 4'b1000);
    tick();
    acc_rise |= btns_rise;
    check_eq("lo_edge11_clean", btns_clean, 4'h0);
    check_eq("lo_no_rise", acc_rise, 4'h0);

    // bounce train 5/3/5 on bit 0 is rejected
    acc_clean = '0; acc_rise = '0;
    btns_raw[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); acc_clean |= btns_clean; acc_rise |= btns_rise; end
    btns_raw[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); acc_clean |= btns_clean; acc_rise |= btns_rise; end
    btns_raw[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); acc_clean |= btns_clean; acc_rise |= btns_rise; end
    btns_raw[0] = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); acc_clean |= btns_clean; acc_rise |= btns_rise; end
    check_eq("bounce_clean", acc_clean, 4'h0);
    check_eq("bounce_rise", acc_rise, 4'h0);

    // boundary: 8-cycle pulse rejected, 9-cycle pulse accepted
    acc_clean = '0;
    btns_raw[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); acc_clean |= btns_clean; end
    btns_raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); acc_clean |= btns_clean; end
    check_eq("pulse8_rejected", acc_clean, 4'h0);
    btns_raw[1] = 1'b1;
    tick(9);
    btns_raw[1] = 1'b0;
    tick();
    check_eq("pulse9_edge10", btns_clean, 4'h0);
    tick();
    check_eq("pulse9_edge11_clean", btns_clean, 4'b0010);
    check_eq("pulse9_edge11_rise", btns_rise, 4'b0010);
    tick(12);
    check_eq("pulse9_released", btns_clean, 4'h0);

    // frame-latched speeds with zero floor
    speed_raw = 8'h70; force_fallback = 1'b0;
    tick(3);
    check_eq("pre_tick_cfg", cfg_update, 1'b0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_eq("f1_ball", ball_speed, 4'd1);
    check_eq("f1_player", player_speed, 4'd7);
    check_eq("f1_cfg", cfg_update, 1'b1);
    tick();
    check_eq("f1_cfg_drop", cfg_update, 1'b0);
    speed_raw = 8'hFF; force_fallback = 1'b1;
    tick(5);
    check_eq("hold_ball", ball_speed, 4'd1);
    check_eq("hold_player", player_speed, 4'd7);
    force_fallback = 1'b0;
    tick(3);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_eq("f2_ball", ball_speed, 4'hF);
    check_eq("f2_player", player_speed, 4'hF);
    check_eq("f2_cfg", cfg_update, 1'b1);

    // fallback forces defaults
    force_fallback = 1'b1; speed_raw = 8'h29;
    tick(3);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_eq("fb_ball", ball_speed, 4'd4);
    check_eq("fb_player", player_speed, 4'd4);

    // back-to-back frame ticks: each loads and each pulses cfg_update
    force_fallback = 1'b0;
    tick(3);
    frame_tick = 1'b1;
    tick();
    check_eq("b2b_1_cfg", cfg_update, 1'b1);
    check_eq("b2b_1_ball", ball_speed, 4'd9);
    check_eq("b2b_1_player", player_speed, 4'd2);
    speed_raw = 8'h00;
    tick();
    frame_tick = 1'b0;
    check_eq("b2b_2_cfg", cfg_update, 1'b1);
    tick();
    check_eq("b2b_end_cfg", cfg_update, 1'b0);
    tick(2);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_eq("zero_ball", ball_speed, 4'd1);
    check_eq("zero_player", player_speed, 4'd1);

    // reset mid-PEND discards the pending press and beats frame_tick
    speed_raw = 8'h29;
    btns_raw = 4'b1111;
    tick(8);
    rst_n = 1'b0; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_eq("midrst_clean", btns_clean, 4'h0);
    check_eq("midrst_ball", ball_speed, 4'd4);
    check_eq("midrst_player", player_speed, 4'd4);
    check_eq("midrst_cfg", cfg_update, 1'b0);
    rst_n = 1'b1;
    tick(10);
    check_eq("postrst_edge10", btns_clean, 4'h0);
    tick();
    check_eq("postrst_edge11_clean", btns_clean, 4'b1111);
    check_eq("postrst_edge11_rise", btns_rise, 4'b1111);
    check_eq("postrst_ball", ball_speed, 4'd4);
    check_eq("postrst_player", player_speed, 4'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
